lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store initiator between the core's memory stage and the word-only data memory
//  (32-bit words, async read, sync write with write_enable, sync reset).
//  Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
//  Sub-word stores use read-modify-write. Misaligned, out-of-range or illegal-funct3 requests are reported, not performed.
// PARAMETERS
//  MEM_BYTES  128  memory size in bytes; legal byte addresses are 0..MEM_BYTES-1
// PORTS
//  clk         in   1   clock
//  reset       in   1   reset, synchronous, active-high
//  req_valid   in   1   request present; held stable until accepted
//  req_ready   out  1   unit idle; request accepted when req_valid & req_ready at posedge
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; low byte/half used for SB/SH
//  resp_valid  out  1   one-cycle response pulse
//  resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
//  resp_err    out  1   valid with resp_valid: misaligned, out-of-range or illegal funct3
//  mem_we      out  1   data memory write enable
//  mem_addr    out  32  word-aligned memory address
//  mem_wdata   out  32  memory write data
//  mem_rdata   in   32  memory read data (combinational from mem_addr)
// BEHAVIOUR
//  - FSM states IDLE, RD, WR, RESP. On reset: state IDLE.
//    Reset outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
//  - IDLE: req_ready=1. On accept, latch we/funct3/addr/wdata.
//    If the request is illegal, go to RESP with err=1. Illegal means any of:
//      * funct3 is 011/110/111;
//      * store with funct3[2]=1;
//      * H/HU/SH with addr[0]=1;
//      * W with addr[1:0]!=0;
//      * addr >= MEM_BYTES.
//    Otherwise go to RD.
//  - RD: mem_addr={addr[31:2],2'b00}, mem_we=0; register mem_rdata into word_q. Load -> RESP; store -> WR.
//  - WR: mem_we=1, same mem_addr. mem_wdata = word_q with the selected lanes replaced:
//      * SB: lane addr[1:0] <= wdata[7:0];
//      * SH: lanes {addr[1],0}..+1 <= wdata[15:0];
//      * SW: whole word.
//    Next state RESP.
//  - RESP: resp_valid=1 for exactly one cycle, req_ready=0, then IDLE.
//    Load extract: byte at addr[1:0] or half at addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
//  - req_ready is 1 only in IDLE, so there is at most one request in flight.
//  - Responses cannot be back-pressured; the consumer must take resp_valid when it pulses.
//  - Latency from the acceptance edge to resp_valid high:
//      * load: 2 cycles;
//      * store: 3 cycles;
//      * error: 1 cycle, with no memory access and mem_we never asserted.
//  - mem_addr=0 in IDLE/RESP. mem_wdata=0 outside WR. mem_we is high only in WR, for exactly 1 cycle per store.
//  - Back-to-back: a new request can be accepted on the first IDLE cycle after RESP.
//  - Reset mid-operation: abandon the request, go to IDLE, no resp_valid.
//    If reset is high in the WR cycle, the memory's own reset wins and the store is lost (documented).
//  - No combinational path from req_* to mem_*: all memory outputs are driven from latched state.
// TESTING
//  - SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> mem_we high 1 cycle; resp_rdata=0xDEADBEEF, err=0.
//  - SB 0x11 wdata=0x000000AA over word 0x11223344 -> memory word 0x1122AA44.
//    Then LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA.
//  - SH 0x12 wdata=0x8001 over word 0 -> word 0x80010000.
//    Then LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
//  - LW 0x12, SH 0x13, LB 0x80 (MEM_BYTES=128), funct3=011 -> each errs 1 cycle after accept.
//    For each: resp_err=1, resp_rdata=0, mem_we never high.
//  - Back-to-back SW 0x0 then LW 0x0 with req_valid held high:
//    second request accepted the cycle after the first RESP; data returns correctly.
//    Check latencies of 3 and 2 cycles.
//  - Assert reset during RD of a store -> no mem_we pulse, no resp_valid.
//    req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store initiator for a word-only data memory.
// Sub-word stores use read-modify-write; illegal requests get an error response and never touch memory.
module lsu_mem_ctrl #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        we_q, err_q, illegal;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, word_q, merged, lane, shifted, load_v;
  logic [3:0]  be;
  logic [7:0]  b_v;
  logic [15:0] h_v;
  assign illegal = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2])
                || (req_funct3[1:0] == 2'b01 && req_addr[0])
                || (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
                || req_addr >= MEM_BYTES;
  assign state_d = state_q == IDLE ? (req_valid ? (illegal ? RESP : RD) : IDLE)
                 : state_q == RD   ? (we_q ? WR : RESP)
                 : state_q == WR   ? RESP : IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      word_q  <= 32'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        err_q   <= illegal;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == RD) word_q <= mem_rdata;
    end
  end
  // Byte enables and replicated store data select the lanes that overwrite the old word
  assign be   = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
              : f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign lane = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
              : f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  always_comb begin
    merged = word_q;
    for (int i = 0; i < 4; i++) if (be[i]) merged[8*i +: 8] = lane[8*i +: 8];
  end
  assign shifted = word_q >> {addr_q[1:0], 3'b000};
  assign b_v     = shifted[7:0];
  assign h_v     = addr_q[1] ? word_q[31:16] : word_q[15:0];
  assign load_v  = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & b_v[7]}}, b_v}
                 : f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & h_v[15]}}, h_v} : word_q;
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_err   = state_q == RESP && err_q;
  assign resp_rdata = (state_q == RESP && !err_q && !we_q) ? load_v : 32'b0;
  assign mem_we     = state_q == WR;
  assign mem_addr   = (state_q == RD || state_q == WR) ? {addr_q[31:2], 2'b00} : 32'b0;
  assign mem_wdata  = state_q == WR ? merged : 32'b0;
endmodule
